// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receive stage: MSB-first deserializer with
// comma-based byte alignment and lock, feeding the lane unstriper.
module serial_paralelo_rx #(
   parameter logic [7:0]  COMMA      = 8'hBC,
   parameter int unsigned SYNC_COUNT = 4
) (
   input  logic       clk_8f,
   input  logic       reset,
   input  logic       enable,
   input  logic       serial_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       byte_strobe,
   output logic       active
);

   typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

   localparam logic [3:0] SYNC = 4'(SYNC_COUNT);

   state_t     state, state_nx;
   logic [6:0] shift;
   logic [7:0] nxt;
   logic [2:0] bit_cnt, bit_cnt_nx;
   logic [3:0] comma_cnt, comma_cnt_nx;
   logic [7:0] data_nx;
   logic       valid_nx, strobe_nx;
   logic       is_comma, boundary;

   // Only seven history bits are kept; the eighth is the incoming bit.
   assign nxt      = {shift, serial_in};
   assign is_comma = (nxt == COMMA);
   assign boundary = (bit_cnt == 3'd7);

   always_ff @(posedge clk_8f) begin
      if (reset) begin
         state       <= SEARCH;
         shift       <= '0;
         bit_cnt     <= '0;
         comma_cnt   <= '0;
         data_out    <= '0;
         valid_out   <= 1'b0;
         byte_strobe <= 1'b0;
      end else if (enable) begin
         state       <= state_nx;
         shift       <= nxt[6:0];
         bit_cnt     <= bit_cnt_nx;
         comma_cnt   <= comma_cnt_nx;
         data_out    <= data_nx;
         valid_out   <= valid_nx;
         byte_strobe <= strobe_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      bit_cnt_nx   = bit_cnt;
      comma_cnt_nx = comma_cnt;
      data_nx      = data_out;
      valid_nx     = valid_out;
      strobe_nx    = 1'b0;
      case (state)
         SEARCH: begin
            // Sliding-window hunt: any bit position may start a byte.
            if (is_comma) begin
               bit_cnt_nx   = 3'd0;
               comma_cnt_nx = 4'd1;
               state_nx     = (SYNC == 4'd1) ? LOCKED : ALIGN;
            end
         end
         ALIGN: begin
            bit_cnt_nx = bit_cnt + 3'd1;
            if (boundary) begin
               if (is_comma) begin
                  comma_cnt_nx = comma_cnt + 4'd1;
                  if (comma_cnt + 4'd1 == SYNC)
                     state_nx = LOCKED;
               end else begin
                  comma_cnt_nx = 4'd0;
                  state_nx     = SEARCH;
               end
            end
         end
         LOCKED: begin
            bit_cnt_nx = bit_cnt + 3'd1;
            if (boundary) begin
               data_nx   = nxt;
               valid_nx  = !is_comma;
               strobe_nx = 1'b1;
            end
         end
         default: state_nx = SEARCH;
      endcase
   end

   always_comb begin
      active = (state == LOCKED);
   end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Self-checking bench for serial_paralelo_rx: vector table plus
// hand-written lock, abort, reset and freeze sequences.
module tb_serial_paralelo_rx;

   logic       clk_8f = 1'b0;
   logic       reset;
   logic       enable;
   logic       serial_in;
   logic [7:0] data_out;
   logic       valid_out;
   logic       byte_strobe;
   logic       active;

   serial_paralelo_rx dut (
      .clk_8f      (clk_8f),
      .reset       (reset),
      .enable      (enable),
      .serial_in   (serial_in),
      .data_out    (data_out),
      .valid_out   (valid_out),
      .byte_strobe (byte_strobe),
      .active      (active)
   );

   always #5 clk_8f = ~clk_8f;

   typedef struct {
      logic [7:0] d;
      logic       v;
   } exp_t;

   typedef struct {
      logic [7:0] din;
      logic [7:0] exp_d;
      logic       exp_v;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[6];
   int   tests  = 0;
   int   failed = 0;
   int   en_cyc = 0;
   int   strobe_at = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: drive, clock, then compare any enabled strobe against the queue.
   task automatic step(input logic s, input logic en);
      exp_t e;
      serial_in = s;
      enable    = en;
      @(posedge clk_8f);
      #1;
      if (en && !reset) begin
         en_cyc++;
         if (byte_strobe) begin
            strobe_at = en_cyc;
            if (sb.size() == 0) begin
               tests++;
               failed++;
               $display("FAIL unexpected strobe: got data %0h expected none",
                        data_out);
            end else begin
               e = sb.pop_front();
               check("sb data", data_out, e.d);
               check("sb valid", valid_out, e.v);
            end
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit push,
                            input logic ev);
      exp_t e;
      for (int i = 7; i >= 0; i--) begin
         if (i == 0 && push) begin
            e.d = b;
            e.v = ev;
            sb.push_back(e);
         end
         step(b[i], 1'b1);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b0, 1'b1);
      reset = 1'b0;
      sb.delete();
   endtask

   task automatic check_zero(input string name);
      check({name, " data"},   data_out, 8'h00);
      check({name, " valid"},  valid_out, 1'b0);
      check({name, " strobe"}, byte_strobe, 1'b0);
      check({name, " active"}, active, 1'b0);
   endtask

   initial begin
      int prev;
      exp_t e;
      vecs[0] = '{8'hAC, 8'hAC, 1'b1};
      vecs[1] = '{8'hBC, 8'hBC, 1'b0};
      vecs[2] = '{8'h0C, 8'h0C, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 1'b1};
      vecs[4] = '{8'hFF, 8'hFF, 1'b1};
      vecs[5] = '{8'h5A, 8'h5A, 1'b1};

      reset     = 1'b1;
      enable    = 1'b1;
      serial_in = 1'b0;

      for (int i = 0; i < 3; i++) begin
         step(1'($urandom_range(1)), 1'b1);
         check_zero("reset");
      end
      reset = 1'b0;
      step(1'b0, 1'b1);
      check_zero("post reset");

      // Lock with a 3-bit offset
      do_reset();
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      for (int k = 0; k < 3; k++) send_byte(8'hBC, 1'b0, 1'b0);
      check("offset active after 3 BC", active, 1'b0);
      for (int i = 7; i >= 1; i--) step(1'($unsigned(8'hBC >> i)), 1'b1);
      check("offset active before LSB", active, 1'b0);
      step(1'b0, 1'b1);
      check("offset active at LSB", active, 1'b1);
      check("offset no lock strobe", byte_strobe, 1'b0);
      send_byte(8'hDD, 1'b1, 1'b1);
      check("offset DD strobe", byte_strobe, 1'b1);
      check("offset DD data", data_out, 8'hDD);

      // Table: byte stream while locked, strobes 8 enabled edges apart
      for (int n = 0; n < 6; n++) begin
         prev = strobe_at;
         for (int i = 7; i >= 0; i--) begin
            if (i == 0) begin
               e.d = vecs[n].exp_d;
               e.v = vecs[n].exp_v;
               sb.push_back(e);
            end
            step(vecs[n].din[i], 1'b1);
            if (i == 7) check("tbl strobe drop", byte_strobe, 1'b0);
         end
         check("tbl strobe", byte_strobe, 1'b1);
         check("tbl spacing", 32'(strobe_at - prev), 32'd8);
      end

      // Lock abort by a non-comma at a boundary
      do_reset();
      for (int k = 0; k < 3; k++) send_byte(8'hBC, 1'b0, 1'b0);
      send_byte(8'h55, 1'b0, 1'b0);
      check("abort active after 55", active, 1'b0);
      for (int k = 0; k < 3; k++) send_byte(8'hBC, 1'b0, 1'b0);
      check("abort active after 3 BC", active, 1'b0);
      send_byte(8'hBC, 1'b0, 1'b0);
      check("abort active after 4 BC", active, 1'b1);
      send_byte(8'hEC, 1'b1, 1'b1);
      check("abort EC data", data_out, 8'hEC);

      // Reset mid-byte, then relock
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      reset = 1'b1;
      step(1'b1, 1'b1);
      check_zero("midreset");
      reset = 1'b0;
      sb.delete();
      send_byte(8'h11, 1'b0, 1'b0);
      check("midreset unlocked", active, 1'b0);
      for (int k = 0; k < 4; k++) send_byte(8'hBC, 1'b0, 1'b0);
      check("midreset relock", active, 1'b1);
      send_byte(8'h11, 1'b1, 1'b1);
      check("midreset 11 data", data_out, 8'h11);
      check("midreset 11 valid", valid_out, 1'b1);

      // Enable freeze in the middle of a byte
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         step(1'(k), 1'b0);
         check("freeze data", data_out, 8'h11);
         check("freeze strobe", byte_strobe, 1'b0);
         check("freeze active", active, 1'b1);
      end
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      check("freeze early strobe", byte_strobe, 1'b0);
      e.d = 8'h88;
      e.v = 1'b1;
      sb.push_back(e);
      step(1'b0, 1'b1);
      check("freeze 88 strobe", byte_strobe, 1'b1);
      check("freeze 88 data", data_out, 8'h88);
      for (int k = 0; k < 2; k++) begin
         step(1'b1, 1'b0);
         check("frozen strobe held", byte_strobe, 1'b1);
      end
      step(1'b0, 1'b1);
      check("strobe after thaw", byte_strobe, 1'b0);
      check("scoreboard drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
